muldiv_seq_unit: RTL and testbench



---
 rtl/muldiv_seq_unit.sv | 212 +++++++++++++++++++++
 tb/tb_muldiv_seq_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq_unit.sv
// Sequential multiply/divide unit with a fixed latency of WIDTH+2 cycles.
// It implements signed and unsigned multiply (full 2W product) and signed and
// unsigned divide (2W dividend, W divisor). Shift-add is used for multiply and
// restoring shift-subtract for divide, on one shared accumulator.
module muldiv_seq_unit #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned OVERFLOW_BIT = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [1:0]           op,
    input  logic [2*WIDTH-1:0]   A_in,
    input  logic [WIDTH-1:0]     B_in,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     res_lo,
    output logic [WIDTH-1:0]     res_hi,
    output logic [3:0]           flag
);

    localparam int unsigned      CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_D = (2*WIDTH)'(1);
    localparam logic [WIDTH-1:0] MIN_MAG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [1:0]             op_r;
    logic [2*WIDTH-1:0]     a_r;
    logic [WIDTH-1:0]       b_r;
    logic [WIDTH-1:0]       mcand;
    logic [2*WIDTH-1:0]     acc;
    logic                   neg_q;
    logic                   neg_r;
    logic                   err;
    logic                   dz;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return ~x + ONE_W;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_d(input logic [2*WIDTH-1:0] x);
        return ~x + ONE_D;
    endfunction

    // Operand decode for PREP: magnitudes, result signs and early error checks
    logic                   sgn;
    logic                   is_div;
    logic                   a_lo_neg;
    logic                   a_hi_neg;
    logic                   b_neg;
    logic [WIDTH-1:0]       mul_a_mag;
    logic [2*WIDTH-1:0]     div_a_mag;
    logic [WIDTH-1:0]       b_mag;
    logic                   div_zero;
    logic                   div_ovf;

    always_comb begin
        sgn       = ~op_r[0];
        is_div    = op_r[1];
        a_lo_neg  = sgn & a_r[WIDTH-1];
        a_hi_neg  = sgn & a_r[2*WIDTH-1];
        b_neg     = sgn & b_r[WIDTH-1];
        mul_a_mag = a_lo_neg ? neg_w(a_r[WIDTH-1:0]) : a_r[WIDTH-1:0];
        div_a_mag = a_hi_neg ? neg_d(a_r) : a_r;
        b_mag     = b_neg ? neg_w(b_r) : b_r;
        div_zero  = (b_r == '0);
        // A magnitude quotient >= 2^W cannot be held in W bits
        div_ovf   = (div_a_mag[2*WIDTH-1:WIDTH] >= b_mag);
    end

    // One iteration of shift-add (multiply) or restoring shift-subtract (divide)
    logic [WIDTH:0]         mul_sum;
    logic [WIDTH:0]         div_shift;
    logic                   div_ge;
    logic [WIDTH-1:0]       div_diff;
    logic [2*WIDTH-1:0]     calc_next;

    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, mcand});
        div_diff  = div_shift[WIDTH-1:0] - mcand;
        if (is_div) begin
            calc_next = {(div_ge ? div_diff : div_shift[WIDTH-1:0]),
                         acc[WIDTH-2:0], div_ge};
        end else begin
            calc_next = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    // Final sign application, signed range check and flag assembly for FIX
    logic [2*WIDTH-1:0]     prod;
    logic [WIDTH-1:0]       q_mag;
    logic [WIDTH-1:0]       r_mag;
    logic [WIDTH-1:0]       q_val;
    logic [WIDTH-1:0]       r_val;
    logic                   range_ovf;
    logic [WIDTH-1:0]       fix_lo;
    logic [WIDTH-1:0]       fix_hi;
    logic [3:0]             fix_flag;

    always_comb begin
        prod      = neg_q ? neg_d(acc) : acc;
        q_mag     = acc[WIDTH-1:0];
        r_mag     = acc[2*WIDTH-1:WIDTH];
        q_val     = neg_q ? neg_w(q_mag) : q_mag;
        r_val     = neg_r ? neg_w(r_mag) : r_mag;
        // A negative quotient may reach -2^(W-1); a positive one must stay below 2^(W-1)
        range_ovf = sgn & (neg_q ? (q_mag > MIN_MAG) : q_mag[WIDTH-1]);
        fix_lo    = '0;
        fix_hi    = '0;
        fix_flag  = '0;
        if (!is_div) begin
            fix_lo      = prod[WIDTH-1:0];
            fix_hi      = prod[2*WIDTH-1:WIDTH];
            fix_flag[1] = (prod == '0);
            fix_flag[0] = sgn & prod[2*WIDTH-1];
        end else if (err || range_ovf) begin
            fix_flag[OVERFLOW_BIT] = 1'b1;
            fix_flag[2]            = dz;
        end else begin
            fix_lo      = q_val;
            fix_hi      = r_val;
            fix_flag[1] = (q_val == '0);
            fix_flag[0] = sgn & q_val[WIDTH-1];
        end
    end

    // Control FSM with registered handshake, datapath and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            op_r   <= '0;
            a_r    <= '0;
            b_r    <= '0;
            mcand  <= '0;
            acc    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            err    <= 1'b0;
            dz     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            res_lo <= '0;
            res_hi <= '0;
            flag   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (en) begin
                        op_r  <= op;
                        a_r   <= A_in;
                        b_r   <= B_in;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        state <= PREP;
                    end
                end
                PREP: begin
                    cnt <= '0;
                    if (is_div) begin
                        mcand <= b_mag;
                        acc   <= div_a_mag;
                        neg_q <= a_hi_neg ^ b_neg;
                        neg_r <= a_hi_neg;
                        err   <= div_zero | div_ovf;
                        dz    <= div_zero;
                    end else begin
                        mcand <= mul_a_mag;
                        acc   <= {{WIDTH{1'b0}}, b_mag};
                        neg_q <= a_lo_neg ^ b_neg;
                        neg_r <= 1'b0;
                        err   <= 1'b0;
                        dz    <= 1'b0;
                    end
                    state <= CALC;
                end
                CALC: begin
                    acc <= calc_next;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    res_lo <= fix_lo;
                    res_hi <= fix_hi;
                    flag   <= fix_flag;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Directed self-checking bench for muldiv_seq_unit (WIDTH=32).
module tb_muldiv_seq_unit;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic            clk;
    logic            reset;
    logic            en;
    logic [1:0]      op;
    logic [2*W-1:0]  A_in;
    logic [W-1:0]    B_in;
    logic            busy;
    logic            done;
    logic [W-1:0]    res_lo;
    logic [W-1:0]    res_hi;
    logic [3:0]      flag;

    int passed = 0;
    int total  = 0;

    localparam logic [1:0] MUL  = 2'b00;
    localparam logic [1:0] MULU = 2'b01;
    localparam logic [1:0] DIV  = 2'b10;
    localparam logic [1:0] DIVU = 2'b11;

    muldiv_seq_unit #(.WIDTH(W), .OVERFLOW_BIT(3)) dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .op     (op),
        .A_in   (A_in),
        .B_in   (B_in),
        .busy   (busy),
        .done   (done),
        .res_lo (res_lo),
        .res_hi (res_hi),
        .flag   (flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]     op;
        logic [2*W-1:0] a;
        logic [W-1:0]   b;
        logic [W-1:0]   lo;
        logic [W-1:0]   hi;
        logic [3:0]     fl;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present an operation and accept it at the next rising edge
    task automatic do_accept(input logic [1:0] o, input logic [2*W-1:0] a,
                             input logic [W-1:0] b, input bit hold, input string tag);
        @(negedge clk);
        op   = o;
        A_in = a;
        B_in = b;
        en   = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) en = 1'b0;
        check({tag, " busy@accept"}, 64'(busy), 64'd1);
        check({tag, " done@accept"}, 64'(done), 64'd0);
    endtask

    // Count edges after acceptance until done rises, bounded
    task automatic wait_done(input int start, output int cyc);
        cyc = start;
        while (done !== 1'b1 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic check_result(input string tag, input int cyc, input logic [W-1:0] lo,
                                input logic [W-1:0] hi, input logic [3:0] fl);
        check({tag, " latency"}, 64'(cyc), 64'(LAT));
        check({tag, " busy@done"}, 64'(busy), 64'd0);
        check({tag, " res_lo"}, 64'(res_lo), 64'(lo));
        check({tag, " res_hi"}, 64'(res_hi), 64'(hi));
        check({tag, " flag"}, 64'(flag), 64'(fl));
    endtask

    int cyc;

    initial begin
        vecs[0]  = '{MUL,  64'h0000_0000_FFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 4'b0001};
        vecs[1]  = '{MULU, 64'h0000_0000_FFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 4'b0000};
        vecs[2]  = '{MUL,  64'h0000_0000_FFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0000};
        vecs[3]  = '{MULU, 64'h0000_0000_0000_0000, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 4'b0010};
        vecs[4]  = '{MUL,  64'h0000_0000_8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h4000_0000, 4'b0000};
        vecs[5]  = '{DIV,  64'hFFFF_FFFF_FFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 4'b0001};
        vecs[6]  = '{DIV,  64'h0000_0000_0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001, 4'b0001};
        vecs[7]  = '{DIVU, 64'h0000_0001_0000_0000, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 4'b1000};
        vecs[8]  = '{DIV,  64'h0000_0000_8000_0000, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 4'b1000};
        vecs[9]  = '{DIVU, 64'h0000_0000_0000_0064, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'b1100};
        vecs[10] = '{DIVU, 64'h0000_0000_0000_0064, 32'h0000_0007, 32'h0000_000E, 32'h0000_0002, 4'b0000};
        vecs[11] = '{DIV,  64'hFFFF_FFFF_FFFF_FFFF, 32'h0000_0002, 32'h0000_0000, 32'hFFFF_FFFF, 4'b0010};
        vecs[12] = '{DIV,  64'hFFFF_FFFF_8000_0000, 32'h0000_0001, 32'h8000_0000, 32'h0000_0000, 4'b0001};
        vecs[13] = '{DIV,  64'hFFFF_FFFF_8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 4'b1000};
        vecs[14] = '{DIVU, 64'hFFFF_FFFE_FFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4'b0000};
        vecs[15] = '{DIV,  64'hFFFF_FFFF_FFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 4'b0000};

        reset = 1'b1;
        en    = 1'b0;
        op    = '0;
        A_in  = '0;
        B_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset res", {res_hi, res_lo}, 64'd0);
        check("reset flag", 64'(flag), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Table of single operations
        for (int i = 0; i < 16; i++) begin
            do_accept(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, $sformatf("v%0d", i));
            wait_done(0, cyc);
            check_result($sformatf("v%0d", i), cyc, vecs[i].lo, vecs[i].hi, vecs[i].fl);
        end

        // en pulsed while busy with different operands is ignored
        do_accept(MULU, 64'd6, 32'd7, 1'b0, "ign");
        repeat (4) @(posedge clk);
        @(negedge clk);
        op   = DIVU;
        A_in = 64'd100;
        B_in = 32'd0;
        en   = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        check("ign busy@E+5", 64'(busy), 64'd1);
        wait_done(5, cyc);
        check_result("ign", cyc, 32'd42, 32'd0, 4'b0000);

        // en held high: second operation accepted from DONE
        do_accept(MULU, 64'd3, 32'd5, 1'b1, "b2b1");
        wait_done(0, cyc);
        check_result("b2b1", cyc, 32'd15, 32'd0, 4'b0000);
        @(negedge clk);
        A_in = 64'd9;
        B_in = 32'd9;
        @(posedge clk);
        #1;
        en = 1'b0;
        check("b2b2 done drop", 64'(done), 64'd0);
        check("b2b2 busy rise", 64'(busy), 64'd1);
        check("b2b2 res hold", 64'(res_lo), 64'd15);
        wait_done(0, cyc);
        check_result("b2b2", cyc, 32'd81, 32'd0, 4'b0000);

        // Reset in the middle of CALC clears everything
        do_accept(MUL, 64'h0000_0000_FFFF_FFFD, 32'd7, 1'b0, "rst");
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst res", {res_hi, res_lo}, 64'd0);
        check("rst flag", 64'(flag), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        do_accept(DIV, 64'h0000_0000_0000_0007, 32'hFFFF_FFFE, 1'b0, "post");
        wait_done(0, cyc);
        check_result("post", cyc, 32'hFFFF_FFFD, 32'd1, 4'b0001);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
